// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer.
// Contents: opcode encodings, one-hot ALU control bit indices, FSM state
// encoding, settle-window select and a one-hot helper.
package alu_pkg;

   localparam int unsigned OP_W   = 5;
   localparam int unsigned CTRL_W = 13;

   localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
   localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
   localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
   localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
   localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
   localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
   localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
   localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
   localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;

   localparam int unsigned CTRL_AND  = 0;
   localparam int unsigned CTRL_OR   = 1;
   localparam int unsigned CTRL_ADD  = 2;
   localparam int unsigned CTRL_SUB  = 3;
   localparam int unsigned CTRL_MUL  = 4;
   localparam int unsigned CTRL_DIV  = 5;
   localparam int unsigned CTRL_SHR  = 6;
   localparam int unsigned CTRL_SHRA = 7;
   localparam int unsigned CTRL_SHL  = 8;
   localparam int unsigned CTRL_ROR  = 9;
   localparam int unsigned CTRL_ROL  = 10;
   localparam int unsigned CTRL_NEG  = 11;
   localparam int unsigned CTRL_NOT  = 12;

   typedef enum logic [1:0] {StIdle, StExec, StDone} state_t;

   // Which settle window an accepted op uses.
   typedef enum logic [1:0] {WaitAlu, WaitMul, WaitDiv} wait_sel_t;

   function automatic logic [CTRL_W-1:0] ctrl_onehot(input int unsigned idx);
      return CTRL_W'(1) << idx;
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bus bundle between the control unit / ALU side and the sequencer.
// Signals: start/opcode/op_a/op_b request, busy/done/err/div_zero status,
// alu_a/alu_b/alu_ctrl drive to the ALU, alu_c result back, z_hi/z_lo captured.
// Modports: master = control unit + ALU side, slave = sequencer.
interface alu_sequencer_if;
   import alu_pkg::*;

   logic              start;
   logic [OP_W-1:0]   opcode;
   logic [31:0]       op_a;
   logic [31:0]       op_b;
   logic              busy;
   logic              done;
   logic              err;
   logic              div_zero;
   logic [31:0]       alu_a;
   logic [31:0]       alu_b;
   logic [CTRL_W-1:0] alu_ctrl;
   logic [63:0]       alu_c;
   logic [31:0]       z_hi;
   logic [31:0]       z_lo;

   modport master (
      output start, opcode, op_a, op_b, alu_c,
      input  busy, done, err, div_zero, alu_a, alu_b, alu_ctrl, z_hi, z_lo
   );

   modport slave (
      input  start, opcode, op_a, op_b, alu_c,
      output busy, done, err, div_zero, alu_a, alu_b, alu_ctrl, z_hi, z_lo
   );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder.
// Ports: i_opcode (5) in; o_ctrl (13) one-hot ALU control; o_legal high for a
// known opcode; o_wait_sel picks the settle window (ALU/MUL/DIV).
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [OP_W-1:0]   i_opcode,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic              o_legal,
   output wait_sel_t         o_wait_sel
);

   always_comb begin
      o_ctrl     = '0;
      o_legal    = 1'b1;
      o_wait_sel = WaitAlu;
      case (i_opcode)
         OP_AND:  o_ctrl = ctrl_onehot(CTRL_AND);
         OP_OR:   o_ctrl = ctrl_onehot(CTRL_OR);
         OP_ADD:  o_ctrl = ctrl_onehot(CTRL_ADD);
         OP_SUB:  o_ctrl = ctrl_onehot(CTRL_SUB);
         OP_SHR:  o_ctrl = ctrl_onehot(CTRL_SHR);
         OP_SHRA: o_ctrl = ctrl_onehot(CTRL_SHRA);
         OP_SHL:  o_ctrl = ctrl_onehot(CTRL_SHL);
         OP_ROR:  o_ctrl = ctrl_onehot(CTRL_ROR);
         OP_ROL:  o_ctrl = ctrl_onehot(CTRL_ROL);
         OP_NEG:  o_ctrl = ctrl_onehot(CTRL_NEG);
         OP_NOT:  o_ctrl = ctrl_onehot(CTRL_NOT);
         OP_MUL: begin
            o_ctrl     = ctrl_onehot(CTRL_MUL);
            o_wait_sel = WaitMul;
         end
         OP_DIV: begin
            o_ctrl     = ctrl_onehot(CTRL_DIV);
            o_wait_sel = WaitDiv;
         end
         default: o_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts an op on start, drives the ALU with frozen operands and
// one-hot control for the op's settle window, then captures the 64-bit result.
// Ports: i_clk, i_reset_n (async, active-low); bus (slave modport) carries the
// request, status, ALU drive/result and the captured z_hi/z_lo.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned ALU_CYCLES = 1,
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 8
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   alu_sequencer_if.slave  bus
);

   localparam int unsigned MAX_CYC_AM = (ALU_CYCLES > MUL_CYCLES) ? ALU_CYCLES : MUL_CYCLES;
   localparam int unsigned MAX_CYC    = (MAX_CYC_AM > DIV_CYCLES) ? MAX_CYC_AM : DIV_CYCLES;
   // Counter only ever holds W-1.
   localparam int unsigned CNT_W      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   state_t            r_state, w_state_d;
   logic [CNT_W-1:0]  r_cnt, w_cnt_d;
   logic [31:0]       r_alu_a, w_alu_a_d;
   logic [31:0]       r_alu_b, w_alu_b_d;
   logic [CTRL_W-1:0] r_ctrl, w_ctrl_d;
   logic              r_busy, w_busy_d;
   logic              r_done, w_done_d;
   logic              r_err, w_err_d;
   logic              r_div_zero, w_div_zero_d;
   logic [63:0]       r_z, w_z_d;

   logic [CTRL_W-1:0] w_dec_ctrl;
   logic              w_dec_legal;
   wait_sel_t         w_dec_wait;
   logic [CNT_W-1:0]  w_wait_cnt;

   alu_op_decode u_op_decode (
      .i_opcode   (bus.opcode),
      .o_ctrl     (w_dec_ctrl),
      .o_legal    (w_dec_legal),
      .o_wait_sel (w_dec_wait)
   );

   always_comb begin
      case (w_dec_wait)
         WaitMul: w_wait_cnt = CNT_W'(MUL_CYCLES - 1);
         WaitDiv: w_wait_cnt = CNT_W'(DIV_CYCLES - 1);
         default: w_wait_cnt = CNT_W'(ALU_CYCLES - 1);
      endcase
   end

   always_comb begin
      w_state_d    = r_state;
      w_cnt_d      = r_cnt;
      w_alu_a_d    = r_alu_a;
      w_alu_b_d    = r_alu_b;
      w_ctrl_d     = r_ctrl;
      w_busy_d     = r_busy;
      w_done_d     = 1'b0;
      w_err_d      = 1'b0;
      w_div_zero_d = 1'b0;
      w_z_d        = r_z;
      case (r_state)
         StIdle: begin
            if (bus.start) begin
               if (!w_dec_legal) begin
                  w_err_d   = 1'b1;
                  w_done_d  = 1'b1;
                  w_state_d = StDone;
               end else if (w_dec_wait == WaitDiv && bus.op_b == '0) begin
                  w_div_zero_d = 1'b1;
                  w_done_d     = 1'b1;
                  w_state_d    = StDone;
               end else begin
                  w_alu_a_d = bus.op_a;
                  w_alu_b_d = bus.op_b;
                  w_ctrl_d  = w_dec_ctrl;
                  w_cnt_d   = w_wait_cnt;
                  w_busy_d  = 1'b1;
                  w_state_d = StExec;
               end
            end
         end
         StExec: begin
            if (r_cnt == '0) begin
               w_z_d     = bus.alu_c;
               w_ctrl_d  = '0;
               w_busy_d  = 1'b0;
               w_done_d  = 1'b1;
               w_state_d = StIdle;
            end else begin
               w_cnt_d = r_cnt - CNT_W'(1);
            end
         end
         StDone:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_ctrl     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_div_zero <= 1'b0;
         r_z        <= '0;
      end else begin
         r_state    <= w_state_d;
         r_cnt      <= w_cnt_d;
         r_alu_a    <= w_alu_a_d;
         r_alu_b    <= w_alu_b_d;
         r_ctrl     <= w_ctrl_d;
         r_busy     <= w_busy_d;
         r_done     <= w_done_d;
         r_err      <= w_err_d;
         r_div_zero <= w_div_zero_d;
         r_z        <= w_z_d;
      end
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.err      = r_err;
   assign bus.div_zero = r_div_zero;
   assign bus.alu_a    = r_alu_a;
   assign bus.alu_b    = r_alu_b;
   assign bus.alu_ctrl = r_ctrl;
   assign bus.z_hi     = r_z[63:32];
   assign bus.z_lo     = r_z[31:0];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, reference model and a scoreboard
// queue drained by a negedge monitor.
module tb_alu_sequencer;
   import alu_pkg::*;

   localparam int unsigned ALU_CYC = 1;
   localparam int unsigned MUL_CYC = 4;
   localparam int unsigned DIV_CYC = 8;

   // Ordered so that the enum value equals the ALU control bit index.
   typedef enum int {KAnd, KOr, KAdd, KSub, KMul, KDiv, KShr, KShra, KShl,
                     KRor, KRol, KNeg, KNot} kind_e;

   typedef struct {
      logic        accepted;
      logic        err;
      logic        dz;
      logic [63:0] z;
      logic [12:0] ctrl;
      logic [31:0] a;
      logic [31:0] b;
      int          k;
      int          w;
      int          done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   bit   in_reset = 1'b1;
   logic [63:0] z_model = '0;
   logic [63:0] alu_c_model;
   exp_t sb_q[$];

   alu_sequencer_if bus ();

   alu_sequencer #(
      .ALU_CYCLES (ALU_CYC),
      .MUL_CYCLES (MUL_CYC),
      .DIV_CYCLES (DIV_CYC)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] op_math(input kind_e k, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [4:0]  s;
      logic [63:0] t;
      s = b[4:0];
      t = {a, a} << s;
      case (k)
         KAnd:  return {32'h0, a & b};
         KOr:   return {32'h0, a | b};
         KAdd:  return {32'h0, a} + {32'h0, b};
         KSub:  return {32'h0, a} - {32'h0, b};
         KMul:  return {32'h0, a} * {32'h0, b};
         KDiv:  return (b == 0) ? 64'h0 : {a % b, a / b};
         KShr:  return {32'h0, a >> s};
         KShra: return {32'h0, 32'($signed(a) >>> s)};
         KShl:  return {32'h0, a << s};
         KRor:  return {32'h0, 32'({a, a} >> s)};
         KRol:  return {32'h0, t[63:32]};
         KNeg:  return {32'h0, 32'h0 - a};
         default: return {32'h0, ~a};
      endcase
   endfunction

   // Behavioural ALU: answers only for a one-hot control word.
   always_comb begin
      alu_c_model = 64'hA5A5_5A5A_DEAD_BEEF;
      if ($onehot(bus.alu_ctrl)) begin
         for (int i = 0; i < 13; i++) begin
            if (bus.alu_ctrl[i]) alu_c_model = op_math(kind_e'(i), bus.alu_a, bus.alu_b);
         end
      end
   end
   assign bus.alu_c = alu_c_model;

   function automatic bit ref_decode(input logic [4:0] opc, output kind_e k);
      k = KAnd;
      case (opc)
         OP_ADD:  k = KAdd;
         OP_SUB:  k = KSub;
         OP_AND:  k = KAnd;
         OP_OR:   k = KOr;
         OP_ROR:  k = KRor;
         OP_ROL:  k = KRol;
         OP_SHR:  k = KShr;
         OP_SHRA: k = KShra;
         OP_SHL:  k = KShl;
         OP_MUL:  k = KMul;
         OP_DIV:  k = KDiv;
         OP_NEG:  k = KNeg;
         OP_NOT:  k = KNot;
         default: return 1'b0;
      endcase
      return 1'b1;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one request at the current negedge and push its expected outcome.
   task automatic issue(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                        output exp_t e);
      kind_e k;
      bit    legal;
      legal      = ref_decode(opc, k);
      e.k        = cyc + 1;
      e.a        = a;
      e.b        = b;
      e.err      = !legal;
      e.dz       = legal && k == KDiv && b == 0;
      e.accepted = legal && !e.dz;
      e.ctrl     = e.accepted ? 13'(1) << int'(k) : 13'h0;
      e.w        = (k == KMul) ? MUL_CYC : (k == KDiv) ? DIV_CYC : ALU_CYC;
      if (!e.accepted) e.w = 0;
      e.done_cyc = e.k + e.w;
      if (e.accepted) z_model = op_math(k, a, b);
      e.z        = z_model;
      sb_q.push_back(e);
      bus.start  = 1'b1;
      bus.opcode = opc;
      bus.op_a   = a;
      bus.op_b   = b;
   endtask

   // Issue, scramble the request lines, wait for done; returns when the next op may go.
   task automatic run_op(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input bit inject);
      exp_t e;
      issue(opc, a, b, e);
      @(negedge clk);
      bus.start  = inject;
      bus.opcode = inject ? OP_AND : 5'($urandom);
      bus.op_a   = $urandom;
      bus.op_b   = $urandom;
      while (cyc < e.done_cyc) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      if (!e.accepted) begin
         bus.start  = inject;
         bus.opcode = OP_AND;
         @(negedge clk);
         bus.start  = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      bit   exp_busy;
      int   idx;
      exp_t cur;
      if (!in_reset) begin
         exp_busy = 1'b0;
         idx      = 0;
         foreach (sb_q[i]) begin
            if (sb_q[i].accepted && cyc >= sb_q[i].k && cyc < sb_q[i].k + sb_q[i].w) begin
               exp_busy = 1'b1;
               idx      = i;
            end
         end
         check("busy", 64'(bus.busy), 64'(exp_busy));
         if (exp_busy) begin
            check("alu_ctrl", 64'(bus.alu_ctrl), 64'(sb_q[idx].ctrl));
            check("alu_a", 64'(bus.alu_a), 64'(sb_q[idx].a));
            check("alu_b", 64'(bus.alu_b), 64'(sb_q[idx].b));
         end else begin
            check("alu_ctrl_idle", 64'(bus.alu_ctrl), 64'h0);
         end
         if (bus.done) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", 64'(bus.done), 64'h0);
            end else begin
               cur = sb_q.pop_front();
               check("done_cycle", 64'(cyc), 64'(cur.done_cyc));
               check("err", 64'(bus.err), 64'(cur.err));
               check("div_zero", 64'(bus.div_zero), 64'(cur.dz));
               check("z", {bus.z_hi, bus.z_lo}, cur.z);
            end
         end else begin
            check("flags_idle", 64'({bus.err, bus.div_zero}), 64'h0);
            if (sb_q.size() != 0 && cyc >= sb_q[0].done_cyc) begin
               check("done_missing", 64'(bus.done), 64'h1);
               void'(sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      exp_t        e;
      logic [4:0]  opc;
      logic [31:0] a;
      logic [31:0] b;
      kind_e       kk;
      int          r;

      reset_n    = 1'b0;
      bus.start  = 1'b0;
      bus.opcode = '0;
      bus.op_a   = '0;
      bus.op_b   = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'h0);
      check("rst_done", 64'({bus.done, bus.err, bus.div_zero}), 64'h0);
      check("rst_ctrl", 64'(bus.alu_ctrl), 64'h0);
      check("rst_z", {bus.z_hi, bus.z_lo}, 64'h0);
      check("rst_ab", {bus.alu_a, bus.alu_b}, 64'h0);
      reset_n  = 1'b1;
      in_reset = 1'b0;
      @(negedge clk);

      run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0);
      check("add_carry", {bus.z_hi, bus.z_lo}, 64'h1_0000_0000);
      run_op(OP_MUL, 32'd7, 32'd6, 1'b1);
      check("mul_42", {bus.z_hi, bus.z_lo}, 64'd42);
      run_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
      run_op(OP_DIV, 32'd17, 32'd5, 1'b0);
      check("div_17_5", {bus.z_hi, bus.z_lo}, {32'd2, 32'd3});
      run_op(OP_DIV, 32'd9, 32'd0, 1'b1);
      check("div0_hold", {bus.z_hi, bus.z_lo}, {32'd2, 32'd3});
      run_op(5'b11111, 32'd1, 32'd2, 1'b0);
      check("illegal_hold", {bus.z_hi, bus.z_lo}, {32'd2, 32'd3});

      // Reset two cycles into a DIV: abort with no capture and no done.
      issue(OP_DIV, 32'd100, 32'd7, e);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      in_reset = 1'b1;
      reset_n  = 1'b0;
      #1;
      check("abort_ctrl", 64'(bus.alu_ctrl), 64'h0);
      check("abort_busy", 64'(bus.busy), 64'h0);
      check("abort_z", {bus.z_hi, bus.z_lo}, 64'h0);
      check("abort_done", 64'(bus.done), 64'h0);
      sb_q.delete();
      z_model = '0;
      repeat (2) @(negedge clk);
      reset_n  = 1'b1;
      in_reset = 1'b0;
      repeat (12) @(negedge clk);

      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 19);
         a = $urandom;
         b = $urandom;
         case (r)
            13, 14: begin
               opc = 5'($urandom);
               while (ref_decode(opc, kk)) opc = 5'($urandom);
            end
            15: begin opc = OP_DIV; b = 32'h0; end
            16: opc = OP_MUL;
            17: begin opc = OP_DIV; b = $urandom_range(1, 1000); end
            default: begin
               opc = 5'($urandom);
               while (!ref_decode(opc, kk)) opc = 5'($urandom);
            end
         endcase
         run_op(opc, a, b, 1'($urandom_range(0, 1)));
      end

      repeat (12) @(negedge clk);
      check("queue_drained", 64'(sb_q.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
